uart_inst_loader: RTL and testbench
===================================

# uart_inst_loader

Boot-time instruction loader for the 16-bit UART CPU. It consumes the byte stream from the UART receiver, frames it into 16-bit instruction words, and writes them into instruction memory from address 0 upward. It holds the pipeline off while a program is being written. It sits between the UART RX block and the instruction-memory write port.

## Interface
- `ADDR_W`, default 8: instruction-memory address width; must be ≥ 8.
- `TIMEOUT_CYCLES`, default 100000: allowed idle clocks between bytes inside a frame.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `rx_frame_err`  in  1  one-cycle strobe; UART framing error on the current byte.
- `imem_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  16  instruction word.
- `cpu_hold`  out  1  stalls PC and pipeline while high.
- `busy`  out  1  high in any state except IDLE.
- `load_done`  out  1  one-cycle pulse on successful load.
- `load_error`  out  1  sticky error flag; cleared on the next accepted header.

## Operation
- Frame format: header 0xA5, count byte N (words, 1..255), then 2N data bytes (high byte first), then checksum byte (only when configured).
- States are IDLE, COUNT, HI, LO, CSUM, DONE.
- **IDLE**
  - An `rx_valid` with 0xA5 goes to COUNT and sets `cpu_hold`.
  - It also clears `load_error`, the word index, the checksum accumulator and the timeout counter.
  - Any other byte is ignored.
- **COUNT**
  - N=0 sets `load_error` and goes to IDLE.
  - Otherwise latch N and go to HI.
- **HI**
  - Latch the byte as `wdata[15:8]`, then go to LO.
  - 0xA5 is treated as data here; there is no resync inside a frame.
- **LO**
  - Latch `wdata[7:0]`. The following cycle issues the write pulse.
  - Go to HI if (index+1) < N.
  - Otherwise go to CSUM when checksum is enabled, or DONE when it is not.
- **CSUM**
  - If the byte equals the running XOR of all 2N data bytes, go to DONE.
  - Otherwise set `load_error` and go to IDLE.
- **DONE**
  - Pulse `load_done`, clear `cpu_hold`, go to IDLE.
- Error paths:
  - `rx_frame_err` in any non-IDLE state sets `load_error` and returns to IDLE.
  - The timeout counter increments each non-IDLE cycle without `rx_valid` and resets on `rx_valid`. Reaching TIMEOUT_CYCLES sets `load_error` and returns to IDLE.
  - After any error, `cpu_hold` stays high. Words already written are not rolled back.
- Word index is ADDR_W bits, starts at 0 and increments after each write. N ≤ 255 < 2^ADDR_W, so the index never wraps.
- Simultaneous `rx_valid` and `rx_frame_err`: the error wins and the byte is discarded.

## Timing
- Reset values:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_hold`=0, `busy`=0, `load_done`=0, `load_error`=0.
  - State = IDLE, all counters 0.
- Reset mid-frame aborts immediately and returns to the reset values; memory contents are untouched.
- One byte is accepted per `rx_valid`. Back-to-back strobes on consecutive clocks must be accepted; there is no backpressure.
- Write latency: `imem_we` is high exactly one cycle, the cycle after the LO byte's `rx_valid`. `imem_addr` and `imem_wdata` are stable during that cycle.
- `load_done` is asserted:
  - one cycle after the final LO write pulse when checksum is disabled;
  - one cycle after the CSUM byte's `rx_valid` when checksum is enabled.
- `cpu_hold` falls in the same cycle as `load_done`. `busy` falls the following cycle.
- `cpu_hold` rises the cycle after the header's `rx_valid`.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - the CSUM state and the 8-bit XOR accumulator are present;
  - a mismatching checksum byte is rejected with `load_error`.
- Not defined:
  - no CSUM state and no accumulator;
  - LO of the last word goes straight to DONE;
  - a byte following the frame is seen in IDLE and ignored unless it is 0xA5.

## Structure
- The shared CPU package holds:
  - the state enumeration;
  - the header constant `LOADER_HDR = 8'hA5`;
  - the count-field width.
- One sub-module, `loader_timeout`, contains the timeout counter with clear/enable inputs and an expiry output.
- The FSM, index, word latch and checksum stay in the top module.

## Test plan
- Load 2 words (A5 02 12 34 AB CD, plus checksum 0x40 if enabled) → writes 0x1234@0 and 0xABCD@1; `load_done` pulses once; `cpu_hold` returns to 0.
- With checksum enabled, send A5 01 11 22 with checksum 0x00 instead of 0x33 → one write; `load_error`=1; `cpu_hold` stays 1; no `load_done`.
- Send A5 00 → `load_error`=1, no writes, state returns to IDLE.
- Send A5 01 12 then pause TIMEOUT_CYCLES → `load_error`=1 and no write. A subsequent valid frame clears the error and loads correctly.
- Pulse `rx_frame_err` during HI → abort with `load_error`. Asserting reset mid-frame → all outputs at reset values within the same cycle.
- Send stray bytes 00 FF 5A in IDLE, then a frame whose data contains 0xA5 → stray bytes are ignored; 0xA5 is written as data.

Source files
------------

// File: rtl/uart_inst_loader_pkg.sv
// Shared definitions for the UART boot-time instruction loader:
// FSM state encoding, frame header constant and count-field width.
package uart_inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE
  } loader_state_t;

  localparam logic [7:0] LOADER_HDR   = 8'hA5;
  localparam int         LOADER_CNT_W = 8;

endpackage

// File: rtl/uart_inst_loader_timeout.sv
// Inter-byte idle watchdog for the instruction loader. expired goes high on
// the TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_inst_loader.sv
// Boot loader: frames UART bytes (A5, N, N x {hi,lo}) into 16-bit words and
// writes them to instruction memory. Optional checksum: UART_LOADER_CHECKSUM_EN.
module uart_inst_loader
  import uart_inst_loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  loader_state_t           state;
  logic [LOADER_CNT_W-1:0] count;
  logic [ADDR_W-1:0]       index;
  logic [7:0]              hi_byte;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif
  logic byte_ok, tmo_clr, tmo_en, tmo_expired, abort;

  // A byte arriving together with a framing error is discarded.
  assign byte_ok = rx_valid && !rx_frame_err;
  assign tmo_clr = (state == ST_IDLE) || rx_valid;
  assign tmo_en  = (state != ST_IDLE) && !rx_valid;
  assign abort   = (state != ST_IDLE) && (rx_frame_err || tmo_expired);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      index      <= '0;
      hi_byte    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      // Errors leave cpu_hold high so a partial program never runs.
      if (abort) begin
        load_error <= 1'b1;
        busy       <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
            if (byte_ok && rx_data == LOADER_HDR) begin
              state      <= ST_COUNT;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              load_error <= 1'b0;
              index      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
              csum       <= '0;
`endif
            end
          end
          ST_COUNT: begin
            if (byte_ok) begin
              if (rx_data == '0) begin
                load_error <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                count <= rx_data;
                state <= ST_HI;
              end
            end
          end
          ST_HI: begin
            if (byte_ok) begin
              hi_byte <= rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
              csum    <= csum ^ rx_data;
`endif
              state   <= ST_LO;
            end
          end
          ST_LO: begin
            if (byte_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= index;
              imem_wdata <= {hi_byte, rx_data};
              index      <= index + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
              csum       <= csum ^ rx_data;
`endif
              if ((index + 1'b1) < ADDR_W'(count)) begin
                state <= ST_HI;
              end else begin
`ifdef UART_LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state <= ST_DONE;
`endif
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (byte_ok) begin
              if (rx_data == csum) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
                state     <= ST_DONE;
              end else begin
                load_error <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_IDLE;
              end
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
`else
          // busy drops one cycle after load_done, from the IDLE branch.
          ST_DONE: begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
            state     <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader; honours UART_LOADER_CHECKSUM_EN.
module tb_uart_inst_loader;

  localparam int ADDR_W = 8;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_frame_err;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold, busy, load_done, load_error;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  logic [23:0] wq[$];
  logic [15:0] fw[$];

  uart_inst_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Memory-side scoreboard: every write and every load_done pulse.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
    if (load_done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load_frame(input int n, input int max_gap, input bit bad);
    int base_w, base_d, got_n;
    logic [7:0] x;
    base_w = wq.size();
    base_d = done_cnt;
    x = 8'h00;
    put(8'hA5);
    compared++;
    if (cpu_hold !== 1'b1 || load_error !== 1'b0) begin
      mismatched++;
      $display("FAIL hdr_hold: hold=%b err=%b want hold=1 err=0", cpu_hold, load_error);
    end
    idle($urandom_range(0, max_gap));
    put(8'(n));
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, max_gap));
      put(fw[i][15:8]);
      idle($urandom_range(0, max_gap));
      put(fw[i][7:0]);
      x = x ^ fw[i][15:8] ^ fw[i][7:0];
      compared++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'(i), fw[i]}) begin
        mismatched++;
        $display("FAIL write_pulse[%0d]: we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 i, imem_we, imem_addr, imem_wdata, 8'(i), fw[i]);
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    idle($urandom_range(0, max_gap));
    put(bad ? ~x : x);
    if (!bad) begin
      compared++;
      if ({load_done, cpu_hold, busy} !== 3'b101) begin
        mismatched++;
        $display("FAIL done_csum: done/hold/busy=%b want 101", {load_done, cpu_hold, busy});
      end
    end else begin
      compared++;
      if ({load_error, cpu_hold, busy, load_done} !== 4'b1100) begin
        mismatched++;
        $display("FAIL bad_csum: err/hold/busy/done=%b want 1100",
                 {load_error, cpu_hold, busy, load_done});
      end
    end
    @(negedge clk);
`else
    @(negedge clk);
    compared++;
    if ({load_done, cpu_hold, busy} !== 3'b101) begin
      mismatched++;
      $display("FAIL done_nocsum: done/hold/busy=%b want 101", {load_done, cpu_hold, busy});
    end
    @(negedge clk);
`endif
    compared++;
    if ({load_done, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL busy_fall: done/busy=%b want 00", {load_done, busy});
    end
    got_n = wq.size() - base_w;
    compared++;
    if (got_n != n) begin
      mismatched++;
      $display("FAIL write_count: got %0d want %0d", got_n, n);
    end
    for (int i = 0; i < n && i < got_n; i++) begin
      compared++;
      if (wq[base_w + i] !== {8'(i), fw[i]}) begin
        mismatched++;
        $display("FAIL mem[%0d]: got %h want %h", i, wq[base_w + i], {8'(i), fw[i]});
      end
    end
    compared++;
    if (done_cnt - base_d != (bad ? 0 : 1)) begin
      mismatched++;
      $display("FAIL done_count: got %0d want %0d", done_cnt - base_d, bad ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
    idle(3);
    compared++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_error} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b want all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_error);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_load();
    fw = {16'h1234, 16'hABCD};
    load_frame(2, 0, 1'b0);
  endtask

  task automatic test_random_loads();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 6);
      fw = {};
      for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
      load_frame(n, (f == 0) ? 0 : 3, 1'b0);
    end
  endtask

  task automatic test_bad_checksum();
`ifdef UART_LOADER_CHECKSUM_EN
    fw = {16'h1122};
    load_frame(1, 0, 1'b1);
`else
    int base;
    fw = {16'h0102};
    load_frame(1, 1, 1'b0);
    base = wq.size();
    put(8'h03);
    idle(3);
    compared++;
    if (busy !== 1'b0 || wq.size() != base) begin
      mismatched++;
      $display("FAIL trailing_byte: busy=%b writes=%0d want busy=0 writes=0", busy, wq.size() - base);
    end
`endif
  endtask

  task automatic test_zero_count();
    int base;
    base = wq.size();
    put(8'hA5);
    put(8'h00);
    compared++;
    if ({load_error, busy, cpu_hold} !== 3'b101) begin
      mismatched++;
      $display("FAIL zero_count: err/busy/hold=%b want 101", {load_error, busy, cpu_hold});
    end
    idle(2);
    compared++;
    if (wq.size() != base) begin
      mismatched++;
      $display("FAIL zero_count_writes: got %0d want 0", wq.size() - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    base = wq.size();
    put(8'hA5);
    put(8'h01);
    put(8'h12);
    idle(TMO - 2);
    compared++;
    if ({load_error, busy} !== 2'b01) begin
      mismatched++;
      $display("FAIL timeout_early: err/busy=%b want 01", {load_error, busy});
    end
    idle(4);
    compared++;
    if ({load_error, busy, cpu_hold} !== 3'b101 || wq.size() != base) begin
      mismatched++;
      $display("FAIL timeout: err/busy/hold=%b writes=%0d want 101 writes=0",
               {load_error, busy, cpu_hold}, wq.size() - base);
    end
    fw = {16'hBEEF, 16'h0F0F, 16'h7001};
    load_frame(3, 2, 1'b0);
  endtask

  task automatic test_frame_err();
    int base;
    base = wq.size();
    put(8'hA5);
    put(8'h02);
    rx_frame_err = 1'b1;
    @(negedge clk);
    rx_frame_err = 1'b0;
    compared++;
    if ({load_error, busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL frame_err_hi: err/busy=%b want 10", {load_error, busy});
    end
    put(8'hA5);
    put(8'h01);
    rx_valid = 1'b1; rx_data = 8'h12; rx_frame_err = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
    put(8'h34);
    idle(2);
    compared++;
    if ({load_error, busy, cpu_hold} !== 3'b101 || wq.size() != base) begin
      mismatched++;
      $display("FAIL frame_err_both: err/busy/hold=%b writes=%0d want 101 writes=0",
               {load_error, busy, cpu_hold}, wq.size() - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    put(8'hA5);
    put(8'h02);
    put(8'h12);
    put(8'h34);
    put(8'hAB);
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_error} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b want all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_error);
    end
    @(negedge clk);
    reset = 1'b1;
    base = wq.size();
    put(8'hCD);
    idle(2);
    compared++;
    if (busy !== 1'b0 || wq.size() != base) begin
      mismatched++;
      $display("FAIL reset_resume: busy=%b writes=%0d want busy=0 writes=0", busy, wq.size() - base);
    end
  endtask

  task automatic test_stray_and_hdr_data();
    put(8'h00);
    put(8'hFF);
    put(8'h5A);
    idle(2);
    compared++;
    if ({busy, cpu_hold} !== 2'b00) begin
      mismatched++;
      $display("FAIL stray_bytes: busy/hold=%b want 00", {busy, cpu_hold});
    end
    fw = {16'hA5A5, 16'h12A5, 16'hA500};
    load_frame(3, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_random_loads();
    test_bad_checksum();
    test_zero_count();
    test_timeout();
    test_frame_err();
    test_reset_mid_frame();
    test_stray_and_hdr_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
